// File: rtl/memc_native_responder.sv
// memc native-port target: cmd/write/read FIFOs in front of an in-order
// burst engine over an internal 512-bit word memory.
// Ports: eclk, rst (async, active-high); memc_cmd_{en,instr,bl,addr,full};
//   memc_wr_{en,end,mask,data,full}; memc_rd_{en,data,empty}; busy; err[3:0].

module memc_nr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  ram [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count_d = count + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
  assign dout    = ram[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_d;
      full  <= (count_d == (AW+1)'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ram[wptr] <= din;
  end
endmodule

module memc_native_responder #(
  parameter int MEM_AW    = 10,
  parameter int CMD_DEPTH = 4,
  parameter int WR_DEPTH  = 64,
  parameter int RD_DEPTH  = 64,
  parameter int RD_DELAY  = 0
) (
  input  logic         eclk,
  input  logic         rst,
  input  logic         memc_cmd_en,
  input  logic [2:0]   memc_cmd_instr,
  input  logic [5:0]   memc_cmd_bl,
  input  logic [27:0]  memc_cmd_addr,
  output logic         memc_cmd_full,
  input  logic         memc_wr_en,
  input  logic         memc_wr_end,
  input  logic [63:0]  memc_wr_mask,
  input  logic [511:0] memc_wr_data,
  output logic         memc_wr_full,
  input  logic         memc_rd_en,
  output logic [511:0] memc_rd_data,
  output logic         memc_rd_empty,
  output logic         busy,
  output logic [3:0]   err
);
  localparam logic [2:0] I_WR = 3'b000;
  localparam logic [2:0] I_RD = 3'b001;
  localparam int CW  = 3 + 6 + MEM_AW;
  localparam int SW  = 16;
  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int WCW = $clog2(WR_DEPTH) + 1;
  localparam int RCW = $clog2(RD_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic [MEM_AW-1:0] beat_idx;

  logic [CW-1:0]     cmd_head;
  logic              cmd_empty;
  logic              cmd_pop;
  logic [CCW-1:0]    cmd_cnt;
  logic [2:0]        head_instr;
  logic [5:0]        head_bl;
  logic [MEM_AW-1:0] head_idx;

  logic [575:0]      wr_head;
  logic [WCW-1:0]    wr_cnt;
  logic              wr_pop;

  logic [511:0]      rd_head;
  logic [RCW-1:0]    rd_cnt;

  logic              mem_we;
  logic              rd_issue;
  logic              bad_cmd;
  logic              is_wr;
  logic              is_rd;
  logic              wr_ok;
  logic              rd_ok;

  logic [511:0]      mem [2**MEM_AW];
  logic [511:0]      pd  [RD_DELAY+1];
  logic [RD_DELAY:0] pv;
  logic              unused_ok;

  memc_nr_fifo #(.W(CW), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk   (eclk),
    .rst   (rst),
    .push  (memc_cmd_en),
    .din   ({memc_cmd_instr, memc_cmd_bl,
             memc_cmd_addr[MEM_AW+2:3]}),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (memc_cmd_full),
    .empty (cmd_empty),
    .count (cmd_cnt)
  );

  memc_nr_fifo #(.W(576), .DEPTH(WR_DEPTH)) u_wr (
    .clk   (eclk),
    .rst   (rst),
    .push  (memc_wr_en),
    .din   ({memc_wr_mask, memc_wr_data}),
    .pop   (wr_pop),
    .dout  (wr_head),
    .full  (memc_wr_full),
    .empty (),
    .count (wr_cnt)
  );

  memc_nr_fifo #(.W(512), .DEPTH(RD_DEPTH)) u_rd (
    .clk   (eclk),
    .rst   (rst),
    .push  (pv[RD_DELAY]),
    .din   (pd[RD_DELAY]),
    .pop   (memc_rd_en),
    .dout  (rd_head),
    .full  (),
    .empty (memc_rd_empty),
    .count (rd_cnt)
  );

  assign {head_instr, head_bl, head_idx} = cmd_head;

  assign is_wr = (head_instr == I_WR) && (head_bl != '0);
  assign is_rd = (head_instr == I_RD) && (head_bl != '0);
  assign wr_ok = SW'(wr_cnt) >= SW'(head_bl);

  // Reserve room for the whole burst plus everything still in the
  // read pipeline so the read FIFO can never overflow.
  assign rd_ok = (SW'(rd_cnt) + SW'($countones(pv))
                + SW'(head_bl) + SW'(RD_DELAY + 1))
                <= SW'(RD_DEPTH);

  always_ff @(posedge eclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      pv      <= '0;
      err     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      pv[0]   <= rd_issue;
      for (int i = 1; i <= RD_DELAY; i++)
        pv[i] <= pv[i-1];
      err <= err | {bad_cmd,
                    memc_rd_en && memc_rd_empty,
                    memc_wr_en && memc_wr_full,
                    memc_cmd_en && memc_cmd_full};
    end
  end

  // The first beat of a burst is done in the decode cycle itself.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    beat_idx = ptr_q;
    mem_we   = 1'b0;
    rd_issue = 1'b0;
    wr_pop   = 1'b0;
    cmd_pop  = 1'b0;
    bad_cmd  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!cmd_empty) begin
          unique case (1'b1)
            is_wr: begin
              if (wr_ok) begin
                beat_idx = head_idx;
                mem_we   = 1'b1;
                wr_pop   = 1'b1;
                ptr_d    = head_idx + MEM_AW'(1);
                cnt_d    = 6'd1;
                if (head_bl == 6'd1) cmd_pop = 1'b1;
                else state_d = S_WRITE;
              end
            end
            is_rd: begin
              if (rd_ok) begin
                beat_idx = head_idx;
                rd_issue = 1'b1;
                ptr_d    = head_idx + MEM_AW'(1);
                cnt_d    = 6'd1;
                if (head_bl == 6'd1) cmd_pop = 1'b1;
                else state_d = S_READ;
              end
            end
            default: begin
              cmd_pop = 1'b1;
              bad_cmd = 1'b1;
            end
          endcase
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        wr_pop = 1'b1;
        ptr_d  = ptr_q + MEM_AW'(1);
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == head_bl - 6'd1) begin
          cmd_pop = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        rd_issue = 1'b1;
        ptr_d    = ptr_q + MEM_AW'(1);
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == head_bl - 6'd1) begin
          cmd_pop = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory and read data path carry no reset: contents survive rst.
  always_ff @(posedge eclk) begin
    if (mem_we) begin
      for (int b = 0; b < 64; b++)
        if (!wr_head[512+b])
          mem[beat_idx][b*8 +: 8] <= wr_head[b*8 +: 8];
    end
    if (rd_issue) pd[0] <= mem[beat_idx];
    for (int i = 1; i <= RD_DELAY; i++)
      pd[i] <= pd[i-1];
  end

  assign memc_rd_data = memc_rd_empty ? '0 : rd_head;
  assign busy = !cmd_empty || (state_q != S_IDLE) || (|pv);

  assign unused_ok = ^{memc_wr_end, cmd_cnt,
                       memc_cmd_addr[27:MEM_AW+3],
                       memc_cmd_addr[2:0]};
endmodule

// File: tb/tb_memc_native_responder.sv
// Bench for memc_native_responder: random bursts checked against a
// word-array memory model and an expected-read queue.

module tb_memc_native_responder;
  localparam int NW = 1024;

  logic         eclk = 1'b0;
  logic         rst  = 1'b1;
  logic         memc_cmd_en    = 1'b0;
  logic [2:0]   memc_cmd_instr = '0;
  logic [5:0]   memc_cmd_bl    = '0;
  logic [27:0]  memc_cmd_addr  = '0;
  logic         memc_cmd_full;
  logic         memc_wr_en     = 1'b0;
  logic         memc_wr_end    = 1'b0;
  logic [63:0]  memc_wr_mask   = '0;
  logic [511:0] memc_wr_data   = '0;
  logic         memc_wr_full;
  logic         memc_rd_en     = 1'b0;
  logic [511:0] memc_rd_data;
  logic         memc_rd_empty;
  logic         busy;
  logic [3:0]   err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] mem_m [NW];
  logic [511:0] exp_q [$];

  memc_native_responder dut (
    .eclk           (eclk),
    .rst            (rst),
    .memc_cmd_en    (memc_cmd_en),
    .memc_cmd_instr (memc_cmd_instr),
    .memc_cmd_bl    (memc_cmd_bl),
    .memc_cmd_addr  (memc_cmd_addr),
    .memc_cmd_full  (memc_cmd_full),
    .memc_wr_en     (memc_wr_en),
    .memc_wr_end    (memc_wr_end),
    .memc_wr_mask   (memc_wr_mask),
    .memc_wr_data   (memc_wr_data),
    .memc_wr_full   (memc_wr_full),
    .memc_rd_en     (memc_rd_en),
    .memc_rd_data   (memc_rd_data),
    .memc_rd_empty  (memc_rd_empty),
    .busy           (busy),
    .err            (err)
  );

  always #5 eclk = ~eclk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge eclk);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_cmd(input logic [2:0] instr,
                          input int bl, input int widx);
    int g = 0;
    while (memc_cmd_full && g < 2000) begin
      tick();
      g++;
    end
    n_checks++;
    if (memc_cmd_full) begin
      n_fail++;
      $display("FAIL cmd_wait got=full want=space");
    end
    memc_cmd_en    = 1'b1;
    memc_cmd_instr = instr;
    memc_cmd_bl    = 6'(bl);
    memc_cmd_addr  = 28'(widx) << 3;
    tick();
    memc_cmd_en = 1'b0;
  endtask

  task automatic push_wr(input logic [511:0] d,
                         input logic [63:0] m);
    int g = 0;
    while (memc_wr_full && g < 2000) begin
      tick();
      g++;
    end
    n_checks++;
    if (memc_wr_full) begin
      n_fail++;
      $display("FAIL wr_wait got=full want=space");
    end
    memc_wr_en   = 1'b1;
    memc_wr_data = d;
    memc_wr_mask = m;
    tick();
    memc_wr_en = 1'b0;
  endtask

  task automatic wr_burst(input int widx, input int bl,
                          input bit rnd_mask);
    logic [511:0] d;
    logic [63:0]  m;
    int w;
    for (int b = 0; b < bl; b++) begin
      d = rnd512();
      m = rnd_mask ? {$urandom, $urandom} : 64'd0;
      push_wr(d, m);
      w = (widx + b) % NW;
      for (int k = 0; k < 64; k++)
        if (!m[k]) mem_m[w][k*8 +: 8] = d[k*8 +: 8];
    end
    push_cmd(3'b000, bl, widx);
  endtask

  task automatic rd_burst(input int widx, input int bl);
    push_cmd(3'b001, bl, widx);
    for (int b = 0; b < bl; b++)
      exp_q.push_back(mem_m[(widx + b) % NW]);
  endtask

  task automatic drain();
    int g = 0;
    logic [511:0] e;
    while (exp_q.size() > 0 && g < 4000) begin
      if (!memc_rd_empty) begin
        e = exp_q.pop_front();
        n_checks++;
        if (memc_rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_beat got=%h want=%h",
                   memc_rd_data, e);
        end
        memc_rd_en = 1'b1;
      end else begin
        memc_rd_en = 1'b0;
      end
      tick();
      g++;
    end
    memc_rd_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d left want=0", exp_q.size());
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 5000) begin
      tick();
      g++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL idle_wait got=busy want=idle");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_checks += 6;
    if (memc_cmd_full !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cmd_full got=%b want=0", memc_cmd_full);
    end
    if (memc_wr_full !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wr_full got=%b want=0", memc_wr_full);
    end
    if (memc_rd_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rd_empty got=%b want=1", memc_rd_empty);
    end
    if (memc_rd_data !== '0) begin
      n_fail++;
      $display("FAIL rst_rd_data got=%h want=0", memc_rd_data);
    end
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got=%b want=0", busy);
    end
    if (err !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_err got=%b want=0000", err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic prefill();
    int bl;
    for (int idx = 0; idx < NW; idx += 63) begin
      bl = (NW - idx < 63) ? NW - idx : 63;
      wr_burst(idx, bl, 1'b0);
    end
    wait_idle();
    n_checks++;
    if (err !== 4'b0000) begin
      n_fail++;
      $display("FAIL prefill_err got=%b want=0000", err);
    end
  endtask

  task automatic test_basic();
    logic [511:0] a5;
    a5 = {64{8'hA5}};
    push_wr(a5, 64'd0);
    push_cmd(3'b000, 1, 8);
    mem_m[8] = a5;
    wait_idle();
    push_cmd(3'b001, 1, 8);
    n_checks += 3;
    if (memc_rd_empty !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_t1 got=%b/%b want=1/1",
               memc_rd_empty, busy);
    end
    tick();
    if (memc_rd_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_t2 got=%b want=1", memc_rd_empty);
    end
    tick();
    if (memc_rd_empty !== 1'b0 || memc_rd_data !== a5) begin
      n_fail++;
      $display("FAIL lat_t3 got=%b %h want=0 %h",
               memc_rd_empty, memc_rd_data, a5);
    end
    memc_rd_en = 1'b1;
    tick();
    memc_rd_en = 1'b0;
    n_checks++;
    if (memc_rd_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_empty got=%b want=1", memc_rd_empty);
    end
  endtask

  task automatic test_mask();
    logic [511:0] old, d, e;
    old = mem_m[5];
    d = rnd512();
    push_wr(d, 64'hFFFF_FFFF_FFFF_FFFE);
    push_cmd(3'b000, 1, 5);
    e = {old[511:8], d[7:0]};
    mem_m[5] = e;
    push_cmd(3'b001, 1, 5);
    exp_q.push_back(e);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [511:0] d;
    d = rnd512();
    memc_wr_en     = 1'b1;
    memc_wr_data   = d;
    memc_wr_mask   = '0;
    memc_cmd_en    = 1'b1;
    memc_cmd_instr = 3'b000;
    memc_cmd_bl    = 6'd1;
    memc_cmd_addr  = 28'(100) << 3;
    tick();
    memc_wr_en     = 1'b0;
    memc_cmd_instr = 3'b001;
    tick();
    memc_cmd_en = 1'b0;
    mem_m[100] = d;
    exp_q.push_back(d);
    drain();
  endtask

  task automatic test_cmd_overflow();
    for (int i = 0; i < 5; i++) begin
      memc_cmd_en    = 1'b1;
      memc_cmd_instr = 3'b000;
      memc_cmd_bl    = 6'd1;
      memc_cmd_addr  = 28'(200 + i) << 3;
      tick();
      if (i == 2) begin
        n_checks++;
        if (memc_cmd_full !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_3rd got=%b want=0", memc_cmd_full);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (memc_cmd_full !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_4th got=%b want=1", memc_cmd_full);
        end
      end
    end
    memc_cmd_en = 1'b0;
    n_checks += 2;
    if (err !== 4'b0001) begin
      n_fail++;
      $display("FAIL ovf_err got=%b want=0001", err);
    end
    if (memc_cmd_full !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold got=%b/%b want=1/1",
               memc_cmd_full, busy);
    end
    do_reset();
    n_checks++;
    if (err !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got=%b/%b want=0000/0", err, busy);
    end
  endtask

  task automatic test_illegal();
    push_cmd(3'b010, 1, 3);
    push_cmd(3'b001, 0, 3);
    rd_burst(7, 1);
    drain();
    wait_idle();
    n_checks++;
    if (err !== 4'b1000) begin
      n_fail++;
      $display("FAIL illegal_err got=%b want=1000", err);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    rd_burst(NW - 1, 4);
    drain();
  endtask

  task automatic test_long_read();
    int idx;
    idx = $urandom_range(0, NW - 1);
    rd_burst(idx, 63);
    wait_idle();
    n_checks++;
    if (memc_rd_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL long_fill got=%b want=0", memc_rd_empty);
    end
    drain();
    tick();
    n_checks++;
    if (memc_rd_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL long_extra got=%b want=1", memc_rd_empty);
    end
    memc_rd_en = 1'b1;
    tick();
    memc_rd_en = 1'b0;
    n_checks++;
    if (err !== 4'b0100 || memc_rd_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow got=%b/%b want=0100/1",
               err, memc_rd_empty);
    end
    do_reset();
  endtask

  task automatic test_reset_midburst();
    logic [511:0] d [8];
    for (int b = 0; b < 8; b++) begin
      d[b] = rnd512();
      push_wr(d[b], 64'd0);
    end
    push_cmd(3'b000, 8, 0);
    tick();
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy got=%b want=1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || memc_cmd_full !== 1'b0 ||
        memc_wr_full !== 1'b0 || memc_rd_empty !== 1'b1 ||
        err !== 4'b0000 || memc_rd_data !== '0) begin
      n_fail++;
      $display("FAIL mid_rst got=%b%b%b%b err=%b want=0001 err=0000",
               busy, memc_cmd_full, memc_wr_full,
               memc_rd_empty, err);
    end
    for (int b = 0; b < 3; b++) mem_m[b] = d[b];
    tick();
    rst = 1'b0;
    tick();
    rd_burst(0, 8);
    drain();
  endtask

  task automatic test_random();
    int idx, bl;
    for (int batch = 0; batch < 5; batch++) begin
      for (int op = 0; op < 6; op++) begin
        idx = $urandom_range(0, NW - 1);
        bl  = $urandom_range(1, 8);
        if ($urandom_range(0, 1) == 1) wr_burst(idx, bl, 1'b1);
        else rd_burst(idx, bl);
      end
      drain();
    end
    wait_idle();
    n_checks++;
    if (err !== 4'b0000) begin
      n_fail++;
      $display("FAIL rand_err got=%b want=0000", err);
    end
  endtask

  initial begin
    test_reset();
    prefill();
    test_basic();
    test_mask();
    test_back_to_back();
    test_wrap();
    test_random();
    test_cmd_overflow();
    test_illegal();
    test_long_read();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
